data_cache: RTL
===============

// Module: data_cache
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache between the pipeline M-stage and a
//  multi-cycle backing data memory. Serves read hits combinationally in the M-stage cycle.
//  Holds the pipeline via stall on read misses (line refill) and on every store (memory write).
// PARAMETERS
//  ADDRESS_WIDTH  32  byte-address width on core and memory sides
//  DATA_WIDTH     32  word width; byte offset addr[1:0] ignored, word accesses only
//  SETS           16  number of lines, power of 2
//  LINE_WORDS      4  words per line, power of 2, >=2
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              synchronous, active-high reset
//  re         in   1              M-stage load (ResultSrcM)
//  we         in   1              M-stage store (MemWriteM)
//  addr       in   ADDRESS_WIDTH  ALUResultM
//  wdata      in   DATA_WIDTH     WriteDataM
//  rdata      out  DATA_WIDTH     load data, valid when re && !stall
//  stall      out  1              freeze F/D/E/M registers, bubble W
//  mem_req    out  1              memory request, held until accepted
//  mem_we     out  1              1 = write beat, 0 = read beat
//  mem_addr   out  ADDRESS_WIDTH  word-aligned beat address
//  mem_wdata  out  DATA_WIDTH     write beat data
//  mem_ready  in   1              beat accepted this cycle; read data valid on mem_rdata
//  mem_rdata  in   DATA_WIDTH     read beat data
// BEHAVIOUR
//  - Address split: word offset = addr[2 +: log2(LINE_WORDS)], index next log2(SETS) bits, tag = rest.
//  - FSM states IDLE, REFILL, WRITE; mem_req = (state != IDLE); mem_we = (state == WRITE).
//  - IDLE, re, hit: rdata = line word, stall = 0, no state change.
//  - IDLE, re, miss: stall = 1.
//    Latch line base address (offset 0) into a request register, beat counter = 0, go REFILL.
//  - REFILL: mem_addr = base + 4*counter.
//    On mem_ready: write mem_rdata into word[counter], counter++.
//    On last beat: write tag, set valid, go IDLE.
//    stall = 1 for the whole state. The next IDLE cycle re-looks-up and hits.
//  - IDLE, we (hit or miss): stall = 1, latch addr/wdata, go WRITE.
//  - WRITE: hold mem_addr/mem_wdata stable.
//    On mem_ready: update cached word if the line is valid with a matching tag, go IDLE.
//    stall = !mem_ready (combinational), so the store retires in the ready cycle.
//  - Minimum latencies with mem_ready tied 1: read miss stalls LINE_WORDS+1 cycles; store stalls 1 cycle.
//  - re && we together: we wins; re is ignored.
//  - Request signals stay stable while mem_req=1 && !mem_ready; mem_ready with mem_req=0 is ignored.
//  - Counter wraps to 0 after the last beat; no beat is issued past LINE_WORDS-1.
//  - rst (any state, incl. mid-refill or mid-write): state IDLE, all valid bits 0, counter 0.
//    Outstanding beat is abandoned and the partial line is not validated.
//    Outputs during/after reset: stall 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata 0.
//  - rdata = 0 whenever !(re && hit && state == IDLE).
//  - Data/tag arrays are not reset; only valid bits are.
// STRUCTURE
//  - cache_pkg: state enum (IDLE/REFILL/WRITE), localparam functions for OFFSET_W, INDEX_W, TAG_W.
//  - Sub-module cache_array: valid/tag/data storage.
//    Comb read by index; sync word write and sync tag+valid write; sync valid clear on rst.
//  - data_cache: address split, hit compare, FSM, beat counter, request register, stall logic.
// TESTING
//  1. Cold read 0x100, mem_ready=1, mem word at A = A^0xA5A5A5A5.
//     -> stall high 5 cycles, beats 0x100..0x10C, then rdata=0xA5A5A4A5.
//  2. Read 0x104 right after test 1 -> hit, stall=0 same cycle, rdata=0xA5A5A4A1, mem_req stays 0.
//  3. Store 0x108 <- 0xDEADBEEF on valid line, mem_ready delayed 3 cycles.
//     -> mem_req/addr/data stable 4 cycles, stall drops in ready cycle; re 0x108 then hits 0xDEADBEEF.
//  4. Store to uncached 0x400 -> one write beat, no refill.
//     Next read 0x400 misses and refills.
//  5. Conflict: read 0x100 then 0x100+16*SETS (same index).
//     -> second refills and evicts; re-read 0x100 misses again.
//  6. rst during beat 2 of a refill -> next cycle mem_req=0, stall=0.
//     Re-read of same address misses, full 4-beat refill.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through data cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    function automatic int offset_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_words);
        return addr_w - 2 - $clog2(sets) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/cache_array.sv
// Valid/tag/data storage: combinational read by index, synchronous writes, valid bits cleared on rst.
module cache_array
    import cache_pkg::*;
#(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_W      = 24,
    parameter int INDEX_W    = index_w(SETS),
    parameter int OFFSET_W   = offset_w(LINE_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_W-1:0]    rd_index,
    input  logic [OFFSET_W-1:0]   rd_offset,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_WIDTH-1:0] rd_word,
    input  logic                  word_we,
    input  logic                  tag_we,
    input  logic [INDEX_W-1:0]    wr_index,
    input  logic [OFFSET_W-1:0]   wr_offset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [TAG_W-1:0]      wr_tag
);

    logic [SETS-1:0]       valid_q;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS][LINE_WORDS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_word  = data_q[rd_index][rd_offset];

    // Only the valid bits are reset; tag and data contents are don't-care until validated.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[wr_index] <= wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (word_we) begin
            data_q[wr_index][wr_offset] <= wr_data;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the M-stage and a
// multi-cycle backing memory; read hits are served combinationally, misses and stores stall.
module data_cache
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETS          = 16,
    parameter int LINE_WORDS    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     re,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ready,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int OFFSET_W = offset_w(LINE_WORDS);
    localparam int INDEX_W  = index_w(SETS);
    localparam int TAG_W    = tag_w(ADDRESS_WIDTH, SETS, LINE_WORDS);
    localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(LINE_WORDS - 1);

    state_t                   state;
    logic [OFFSET_W-1:0]      count;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;

    logic [ADDRESS_WIDTH-1:0] look_addr;
    logic                     rd_valid;
    logic [TAG_W-1:0]         rd_tag;
    logic [DATA_WIDTH-1:0]    rd_word;
    logic                     hit;
    logic                     word_we;
    logic                     tag_we;
    logic [OFFSET_W-1:0]      wr_offset;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic                     unused_low_bits;

    // Outside IDLE the lookup follows the latched request so a store can update its own line.
    assign look_addr       = (state == IDLE) ? addr : req_addr;
    assign hit             = rd_valid && (rd_tag == look_addr[ADDRESS_WIDTH-1 -: TAG_W]);
    assign unused_low_bits = ^look_addr[1:0];

    assign wr_offset = (state == REFILL) ? count : req_addr[2 +: OFFSET_W];
    assign wr_data   = (state == WRITE) ? req_wdata : mem_rdata;
    assign word_we   = !rst && mem_ready && ((state == REFILL) || (state == WRITE && hit));
    assign tag_we    = !rst && mem_ready && (state == REFILL) && (count == LAST_BEAT);

    cache_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (look_addr[2+OFFSET_W +: INDEX_W]),
        .rd_offset (look_addr[2 +: OFFSET_W]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_word   (rd_word),
        .word_we   (word_we),
        .tag_we    (tag_we),
        .wr_index  (req_addr[2+OFFSET_W +: INDEX_W]),
        .wr_offset (wr_offset),
        .wr_data   (wr_data),
        .wr_tag    (req_addr[ADDRESS_WIDTH-1 -: TAG_W])
    );

    assign mem_req   = !rst && (state != IDLE);
    assign mem_we    = !rst && (state == WRITE);
    assign mem_wdata = (!rst && state == WRITE) ? req_wdata : '0;
    assign rdata     = (!rst && state == IDLE && re && !we && hit) ? rd_word : '0;

    always_comb begin
        mem_addr = '0;
        stall    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    stall = we || (re && !hit);
                REFILL: begin
                    stall    = 1'b1;
                    mem_addr = {req_addr[ADDRESS_WIDTH-1:2+OFFSET_W], count, 2'b00};
                end
                WRITE: begin
                    stall    = !mem_ready;
                    mem_addr = req_addr;
                end
                default: stall = 1'b0;
            endcase
        end
    end

    // A store takes priority over a load; a refill walks the line from word 0 and validates on the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (we) begin
                        req_addr  <= {addr[ADDRESS_WIDTH-1:2], 2'b00};
                        req_wdata <= wdata;
                        state     <= WRITE;
                    end else if (re && !hit) begin
                        req_addr <= {addr[ADDRESS_WIDTH-1:2+OFFSET_W], {(OFFSET_W+2){1'b0}}};
                        count    <= '0;
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        count <= count + OFFSET_W'(1);
                        if (count == LAST_BEAT) begin
                            state <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
